pipeline_control_unit: RTL
==========================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, meaning memory-wait cycles before the timeout error is flagged.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Ports: id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 Ports: ex_mem_read  input  1, and ex_rd  input  5  load-in-EX flag and destination register.
REQ-006 Ports: mem_branch  input  1, mem_zero  input  1, mem_less  input  1, mem_funct3  input  3  branch resolution inputs from the EX/MEM stage.
REQ-007 Ports: mem_access  input  1  load or store present in MEM; dmem_ready  input  1  data memory completion.
REQ-008 Outputs, 1 bit each: pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  pipeline register enables.
REQ-009 Outputs, 1 bit each: if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble  insert NOP.
REQ-010 Outputs, 1 bit each: pc_src  selects branch target; dmem_req  memory request.
REQ-011 Output: mem_timeout  1  sticky error.
REQ-012 Outputs: stall_cycles  32  saturating count; flush_count  16  wrapping count.

Function
REQ-013 Branch taken SHALL be decoded as mem_branch AND: funct3 000 zero; 001 !zero; 100 less; 101 !less; any other funct3 not taken.
REQ-014 Load-use hazard SHALL be decoded as ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-015 FSM states SHALL be RUN and MEM_WAIT.
REQ-016 Transition RUN->MEM_WAIT when mem_access & !dmem_ready; MEM_WAIT->RUN when dmem_ready.
REQ-017 dmem_req SHALL equal mem_access in RUN and SHALL be held at 1 throughout MEM_WAIT.
REQ-018 Memory stall condition is (RUN & mem_access & !dmem_ready) or (MEM_WAIT & !dmem_ready). While it holds, all write enables SHALL be 0, mem_wb_bubble SHALL be 1, no flushes SHALL assert, and pc_src SHALL be 0.
REQ-019 Priority: memory stall > taken branch > load-use; lower-priority events are ignored in that cycle and re-evaluated on the next cycle.
REQ-020 Taken branch: pc_src=1, if_id_flush=id_ex_flush=ex_mem_flush=1, all write enables=1, all in the same cycle (zero latency).
REQ-021 Load-use: pc_write=if_id_write=0, id_ex_flush=1, and the remaining enables stay 1 for exactly the cycle(s) the hazard is present.
REQ-022 With no event, all write enables SHALL be 1, all flushes and bubble 0, and pc_src 0.
REQ-023 The cycle in MEM_WAIT where dmem_ready=1 SHALL release the stall combinationally, with all enables 1.
REQ-024 stall_cycles SHALL increment once per cycle with any memory or load-use stall asserted, saturating at 0xFFFFFFFF.
REQ-025 flush_count SHALL increment by 1 per taken-branch cycle and wrap modulo 2^16.
REQ-026 A wait counter SHALL count MEM_WAIT cycles; mem_timeout SHALL set when the count reaches TIMEOUT_CYCLES and stay set until reset. The wait counter SHALL clear on MEM_WAIT exit.

Reset
REQ-027 Reset is synchronous: state=RUN, stall_cycles=0, flush_count=0, wait counter=0, mem_timeout=0.
REQ-028 Reset asserted in MEM_WAIT SHALL abandon the access; dmem_req SHALL be 0 in the next cycle unless mem_access=1.
REQ-029 During reset, outputs follow the RUN-state equations.

Structure
REQ-030 Shared package SHALL hold FSM state encodings and the funct3 branch codes (BEQ/BNE/BLT/BGE).
REQ-031 One sub-module, hazard_detect (combinational load-use compare), is natural; the FSM and counters stay in the top.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs2=5, no mem_access -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles +1.
REQ-033 mem_branch=1, funct3=001, zero=0 -> pc_src=1, three flushes=1, flush_count +1; with zero=1 -> no flush.
REQ-034 mem_access=1, dmem_ready held 0 for 3 cycles then 1 -> enables 0 for 3 cycles, dmem_req=1 for 4 cycles, stall_cycles +3, state back to RUN.
REQ-035 Load-use, taken branch and mem stall in the same cycle -> only the stall response; with the stall absent, branch wins and id_ex_flush=1, pc_write=1.
REQ-036 dmem_ready low for 255 cycles -> mem_timeout=1 and stays 1 after ready; reset mid-wait -> RUN, counters 0.
REQ-037 Preload stall_cycles to 0xFFFFFFFF by force, then stall -> value holds; flush_count 0xFFFF plus one branch -> 0x0000.

Source files
------------

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: FSM encoding, branch funct3
// codes and the bundled pipeline-control response.
package pipeline_control_unit_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pcu_state_e;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_bubble;
        logic pc_src;
    } pcu_ctrl_t;

    localparam pcu_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        mem_wb_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b0, pc_src: 1'b0
    };

    // Freeze the whole pipe and feed a bubble into WB while memory is busy.
    localparam pcu_ctrl_t CTRL_STALL = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        mem_wb_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b1, pc_src: 1'b0
    };

    localparam pcu_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        mem_wb_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
        mem_wb_bubble: 1'b0, pc_src: 1'b1
    };

    // Hold PC and IF/ID, let the load advance, put a NOP into EX behind it.
    localparam pcu_ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        mem_wb_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0,
        mem_wb_bubble: 1'b0, pc_src: 1'b0
    };

    function automatic logic branch_taken(
        input logic       branch,
        input logic [2:0] funct3,
        input logic       zero,
        input logic       less
    );
        logic cond;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = !zero;
            F3_BLT:  cond = less;
            F3_BGE:  cond = !less;
            default: cond = 1'b0;
        endcase
        return branch && cond;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module pipeline_control_unit_hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control: memory-wait FSM, branch flush and load-use stall arbitration,
// plus stall/flush statistics and a sticky memory timeout.
//
//   state       | meaning
//   ST_RUN      | pipeline flowing; a MEM access without ready starts a wait
//   ST_MEM_WAIT | data memory access outstanding; dmem_req held until ready
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_less,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_bubble,
    output logic        pc_src,
    output logic        dmem_req,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    pcu_state_e        state;
    pcu_state_e        state_eff;
    pcu_state_e        state_next;
    pcu_ctrl_t         ctrl;
    logic              load_use;
    logic              taken;
    logic              mem_stall;
    logic              branch_event;
    logic              load_use_event;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;

    pipeline_control_unit_hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    // Reset is synchronous, so during the reset cycle the outputs already behave
    // as RUN; this is what abandons an access that was stuck in MEM_WAIT.
    assign state_eff = reset ? ST_RUN : state;
    assign taken     = branch_taken(mem_branch, mem_funct3, mem_zero, mem_less);

    always_comb begin
        state_next = state_eff;
        ctrl       = CTRL_RUN;
        dmem_req   = mem_access;
        mem_stall  = 1'b0;

        case (state_eff)
            ST_RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_next = ST_MEM_WAIT;
                    mem_stall  = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_next = ST_RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase

        if (mem_stall) begin
            ctrl = CTRL_STALL;
        end else if (taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign branch_event   = taken && !mem_stall;
    assign load_use_event = load_use && !taken && !mem_stall;

    // The wait count covers every cycle the access is outstanding, including the
    // RUN cycle that enters MEM_WAIT, and saturates at the limit.
    always_comb begin
        wait_cnt_next = '0;
        if (mem_stall) begin
            wait_cnt_next = (wait_cnt == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if ((mem_stall || load_use_event) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_event) begin
                flush_count <= flush_count + 16'd1;
            end
            if (mem_stall && (wait_cnt_next == WAIT_LIMIT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_write  = ctrl.mem_wb_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_flush  = ctrl.ex_mem_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign pc_src        = ctrl.pc_src;

endmodule
